// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/func encodings, reset PC, nop encoding and
// the next-PC source selector. Used by fetch, decode and the hazard unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUBU = 6'h23;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BEQ,
    NPC_JUMP,
    NPC_JR
  } npc_sel_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/im_rom.sv
// Instruction ROM with a combinational read port. The image is supplied as a
// packed parameter (word i at bits [32*i +: 32]) so the contents are fixed at
// elaboration without any load-time file access.
module im_rom #(
  parameter int                        IM_WORDS = 1024,
  parameter logic [32*IM_WORDS-1:0]    IM_INIT  = '0
) (
  input  logic [$clog2(IM_WORDS)-1:0]  addr_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem [IM_WORDS];

  // Unpack the image into addressable words.
  for (genvar i = 0; i < IM_WORDS; i++) begin : g_word
    assign mem[i] = IM_INIT[32*i +: 32];
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID pipeline register. Next PC is resolved
// from the D-stage instruction with a single delay slot (no flush). A stall
// from the hazard unit freezes PC and IF/ID and suppresses redirects.
// Optional: FETCH_ALIGN_CHECK_EN enables misaligned / out-of-range fetch
// detection (nop substituted, sticky fetch_err). Without it, fetches wrap
// modulo IM_WORDS and fetch_err stays 0.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0]               PC_RESET = PC_RESET_DEF,
  parameter int                        IM_WORDS = 1024,
  parameter logic [32*IM_WORDS-1:0]    IM_INIT  = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        cmp_eq,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        fetch_err
);

  localparam int AW = $clog2(IM_WORDS);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] dir_q, dir_d;
  logic [31:0] dpc_q, dpc_d;
  logic        err_q, err_d;

  logic [31:0] off;
  logic [31:0] instr_f;
  logic        fault;
  logic [31:0] pc4_d;
  logic [31:0] npc;
  npc_sel_e    npc_sel;

  assign off = fpc_q - PC_RESET;

  im_rom #(
    .IM_WORDS (IM_WORDS),
    .IM_INIT  (IM_INIT)
  ) u_rom (
    .addr_i  (off[AW+1:2]),
    .rdata_o (instr_f)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic unused_off;
  assign unused_off = ^off[1:0];
  // Negative offsets wrap to large values, so one upper-bits test covers both ends.
  assign fault = (fpc_q[1:0] != 2'b00) || (off[31:AW+2] != '0);
`else
  logic unused_off;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
  assign fault = 1'b0;
`endif

  assign pc4_d = dpc_q + 32'd4;

  // Redirect source decoded from the instruction sitting in D.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (dir_q[31:26] == OP_BEQ && cmp_eq) begin
      npc_sel = NPC_BEQ;
    end else if (dir_q[31:26] == OP_J || dir_q[31:26] == OP_JAL) begin
      npc_sel = NPC_JUMP;
    end else if (dir_q[31:26] == OP_RTYPE && dir_q[5:0] == FUNC_JR) begin
      npc_sel = NPC_JR;
    end
  end

  // Next-PC mux.
  always_comb begin
    npc = fpc_q + 32'd4;
    case (npc_sel)
      NPC_BEQ:  npc = pc4_d + (sext16(dir_q[15:0]) << 2);
      NPC_JUMP: npc = {pc4_d[31:28], dir_q[25:0], 2'b00};
      NPC_JR:   npc = jr_target;
      default:  npc = fpc_q + 32'd4;
    endcase
  end

  // Advance PC and IF/ID unless stalled; faulting fetches become nops.
  always_comb begin
    fpc_d = fpc_q;
    dir_d = dir_q;
    dpc_d = dpc_q;
    err_d = err_q;
    if (!stall) begin
      fpc_d = npc;
      dir_d = fault ? NOP : instr_f;
      dpc_d = fpc_q;
      err_d = err_q | fault;
    end
  end

  // Pipeline state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_q <= PC_RESET;
      dir_q <= NOP;
      dpc_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      fpc_q <= fpc_d;
      dir_q <= dir_d;
      dpc_q <= dpc_d;
      err_q <= err_d;
    end
  end

  assign pc_f      = fpc_q;
  assign ir_d      = dir_q;
  assign pc_d      = dpc_q;
  assign pc8_d     = dpc_q + 32'd8;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall hold, beq/jal/jr
// redirects with delay slot, stalled jr, out-of-range and misaligned fetch,
// reset during stall. Expectations follow FETCH_ALIGN_CHECK_EN if defined.
module tb_fetch_stage;

  localparam int          WORDS = 64;
  localparam logic [31:0] PCR   = 32'h0000_3000;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  function automatic logic [32*WORDS-1:0] mk_prog();
    logic [32*WORDS-1:0] p;
    p = '0;
    p[32*0  +: 32] = 32'h3c01_1234; // 0x3000 lui
    p[32*1  +: 32] = 32'h3421_0001; // 0x3004 ori
    p[32*2  +: 32] = 32'h0000_0000; // 0x3008 nop
    p[32*3  +: 32] = 32'h03e0_0008; // 0x300c jr
    p[32*4  +: 32] = 32'h1000_0003; // 0x3010 beq +3
    p[32*5  +: 32] = 32'h0000_0001; // 0x3014 delay-slot marker
    p[32*8  +: 32] = 32'h0c00_0c10; // 0x3020 jal 0xc10
    p[32*9  +: 32] = 32'h0000_0002; // 0x3024 delay-slot marker
    p[32*16 +: 32] = 32'h03e0_0008; // 0x3040 jr
    p[32*17 +: 32] = 32'h0000_0005; // 0x3044 delay-slot marker
    return p;
  endfunction

  localparam logic [32*WORDS-1:0] PROG = mk_prog();

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        cmp_eq;
  logic [31:0] jr_target;
  logic [31:0] pc_f, ir_d, pc_d, pc8_d;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .PC_RESET (PCR),
    .IM_WORDS (WORDS),
    .IM_INIT  (PROG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .cmp_eq    (cmp_eq),
    .jr_target (jr_target),
    .pc_f      (pc_f),
    .ir_d      (ir_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pipe(input string tag, input logic [31:0] epc, input logic [31:0] eir,
                          input logic [31:0] epcd);
    chk({tag, ".pc_f"}, pc_f, epc);
    chk({tag, ".ir_d"}, ir_d, eir);
    chk({tag, ".pc_d"}, pc_d, epcd);
  endtask

  initial begin
    reset     = 1'b0;
    stall     = 1'b0;
    cmp_eq    = 1'b0;
    jr_target = 32'h0000_3014;
    step();
    step();
    chk_pipe("rst", 32'h3000, 32'h0, 32'h0);
    chk("rst.pc8_d", pc8_d, 32'h8);
    chk("rst.err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b1;

    step(); chk_pipe("e1", 32'h3004, 32'h3c01_1234, 32'h3000);
    step(); chk_pipe("e2", 32'h3008, 32'h3421_0001, 32'h3004);
    stall = 1'b1;
    step(); chk_pipe("stall1", 32'h3008, 32'h3421_0001, 32'h3004);
    step(); chk_pipe("stall2", 32'h3008, 32'h3421_0001, 32'h3004);
    stall = 1'b0;
    step(); chk_pipe("e5", 32'h300c, 32'h0, 32'h3008);
    step(); chk_pipe("e6", 32'h3010, 32'h03e0_0008, 32'h300c);
    step(); chk_pipe("jr_seq", 32'h3014, 32'h1000_0003, 32'h3010);
    cmp_eq = 1'b1;
    step(); chk_pipe("beq", 32'h3020, 32'h0000_0001, 32'h3014);
    cmp_eq = 1'b0;
    step(); chk_pipe("e9", 32'h3024, 32'h0c00_0c10, 32'h3020);
    chk("jal.pc8_d", pc8_d, 32'h3028);
    step(); chk_pipe("jal", 32'h3040, 32'h0000_0002, 32'h3024);
    step(); chk_pipe("e11", 32'h3044, 32'h03e0_0008, 32'h3040);

    stall = 1'b1; jr_target = 32'h3060; cmp_eq = 1'b1;
    step(); chk_pipe("jrst1", 32'h3044, 32'h03e0_0008, 32'h3040);
    step(); chk_pipe("jrst2", 32'h3044, 32'h03e0_0008, 32'h3040);
    stall = 1'b0; jr_target = 32'h3020; cmp_eq = 1'b0;
    step(); chk_pipe("jr_rel", 32'h3020, 32'h0000_0005, 32'h3044);
    step(); chk_pipe("e15", 32'h3024, 32'h0c00_0c10, 32'h3020);
    step(); chk("e16.pc_f", pc_f, 32'h3040);
    step(); chk("e17.ir_d", ir_d, 32'h03e0_0008);
    jr_target = 32'h3104;
    step(); chk_pipe("jr_oor", 32'h3104, 32'h0000_0005, 32'h3044);
    chk("e18.err", {31'd0, fetch_err}, 32'd0);
    step(); chk_pipe("oor", 32'h3108, ALN ? 32'h0 : 32'h3421_0001, 32'h3104);
    chk("oor.err", {31'd0, fetch_err}, {31'd0, ALN});
    step(); chk("oor2.pc_f", pc_f, 32'h310c);
    chk("oor2.err", {31'd0, fetch_err}, {31'd0, ALN});

    reset = 1'b0; stall = 1'b1;
    step(); chk_pipe("rst2", 32'h3000, 32'h0, 32'h0);
    chk("rst2.err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b1; stall = 1'b0;
    step(); chk_pipe("b1", 32'h3004, 32'h3c01_1234, 32'h3000);
    step(); step();
    step(); chk_pipe("b4", 32'h3010, 32'h03e0_0008, 32'h300c);
    jr_target = 32'h3002;
    step(); chk_pipe("b5", 32'h3002, 32'h1000_0003, 32'h3010);
    chk("b5.err", {31'd0, fetch_err}, 32'd0);
    step(); chk_pipe("mis", 32'h3006, ALN ? 32'h0 : 32'h3c01_1234, 32'h3002);
    chk("mis.err", {31'd0, fetch_err}, {31'd0, ALN});
    stall = 1'b1;
    step(); chk_pipe("mis_st", 32'h3006, ALN ? 32'h0 : 32'h3c01_1234, 32'h3002);
    chk("mis_st.err", {31'd0, fetch_err}, {31'd0, ALN});
    reset = 1'b0;
    step(); chk("rst3.err", {31'd0, fetch_err}, 32'd0);
    chk("rst3.pc_f", pc_f, 32'h3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
